// File: rtl/mul_dot_accumulator.sv
// Sums len_i unsigned products into a saturating ACC_W-bit result.
// The sum is valid one cycle after the last product and held until sum_ready_i; no products are taken in IDLE or HOLD.
module mul_dot_accumulator #(
  parameter int N     = 16,
  parameter int PW    = 2*N,
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             prod_valid_i,
  input  logic [PW-1:0]    prod_i,
  output logic             prod_ready_o,
  output logic             busy_o,
  output logic             sum_valid_o,
  output logic [ACC_W-1:0] sum_o,
  input  logic             sum_ready_i,
  output logic             overflow_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic             accept;
  logic [ACC_W:0]   add_w;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt_inc;
  logic             last;

  assign accept   = (state_q == ACCUM) && prod_valid_i;
  assign add_w    = {1'b0, acc_q} + {{(ACC_W+1-PW){1'b0}}, prod_i};
  assign carry    = add_w[ACC_W];
  // An all-ones accumulator re-saturates on any non-zero add, so it stays pinned.
  assign acc_next = carry ? {ACC_W{1'b1}} : add_w[ACC_W-1:0];
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign last     = (cnt_inc == len_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? HOLD : ACCUM;
      ACCUM:   if (accept && last) state_d = HOLD;
      HOLD:    if (sum_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= len_i;
            ovf_q <= 1'b0;
            if (len_i == '0) sum_q <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_next;
            cnt_q <= cnt_inc;
            if (carry) ovf_q <= 1'b1;
            if (last)  sum_q <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign prod_ready_o = (state_q == ACCUM);
  assign busy_o       = (state_q != IDLE);
  assign sum_valid_o  = (state_q == HOLD);
  assign sum_o        = sum_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Drives a 40-bit and a 33-bit accumulator with identical vectors; a monitor pops expected sums at each handshake.
module tb_mul_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [31:0] prod;
  logic        sum_ready;

  logic        prod_ready_a, busy_a, sum_valid_a, ovf_a;
  logic [39:0] sum_a;
  logic        prod_ready_b, busy_b, sum_valid_b, ovf_b;
  logic [32:0] sum_b;

  typedef struct {
    logic [39:0] sum;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_dot_accumulator dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .prod_valid_i(prod_valid), .prod_i(prod), .prod_ready_o(prod_ready_a),
    .busy_o(busy_a), .sum_valid_o(sum_valid_a), .sum_o(sum_a),
    .sum_ready_i(sum_ready), .overflow_o(ovf_a)
  );

  mul_dot_accumulator #(.ACC_W(33)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
    .prod_valid_i(prod_valid), .prod_i(prod), .prod_ready_o(prod_ready_b),
    .busy_o(busy_b), .sum_valid_o(sum_valid_b), .sum_o(sum_b),
    .sum_ready_i(sum_ready), .overflow_o(ovf_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_prod(input logic [31:0] p);
    prod_valid = 1'b1;
    prod       = p;
    step();
    prod_valid = 1'b0;
  endtask

  task automatic take_sum();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  task automatic expect_sum(input logic [39:0] sa, input logic oa, input logic [39:0] sb, input logic ob);
    qa.push_back('{sum: sa, ovf: oa});
    qb.push_back('{sum: sb, ovf: ob});
  endtask

  always @(negedge clk) begin
    if (!rst && sum_ready) begin
      if (sum_valid_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sum_a: got 0x%0h, expected no sum", sum_a);
        end else begin
          ea = qa.pop_front();
          check("sum_a", 64'(sum_a), 64'(ea.sum));
          check("ovf_a", 64'(ovf_a), 64'(ea.ovf));
        end
      end
      if (sum_valid_b) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sum_b: got 0x%0h, expected no sum", sum_b);
        end else begin
          eb = qb.pop_front();
          check("sum_b", 64'(sum_b), 64'(eb.sum));
          check("ovf_b", 64'(ovf_b), 64'(eb.ovf));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; sum_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_prod_ready", 64'(prod_ready_a), 64'd0);
    check("rst_busy",       64'(busy_a),       64'd0);
    check("rst_sum_valid",  64'(sum_valid_a),  64'd0);
    check("rst_sum",        64'(sum_a),        64'd0);
    check("rst_ovf",        64'(ovf_a),        64'd0);
    rst = 1'b0;
    step();

    // Basic vector; the 33-bit instance saturates on the third product.
    start_vec(8'd3);
    @(negedge clk);
    check("accum_prod_ready", 64'(prod_ready_a), 64'd1);
    check("accum_busy",       64'(busy_a),       64'd1);
    send_prod(32'hFFFE0001);
    send_prod(32'hFFFE0001);
    send_prod(32'hFFFE0001);
    expect_sum(40'h2FFFA0003, 1'b0, 40'h1FFFFFFFF, 1'b1);
    @(negedge clk);
    check("basic_sum_valid",  64'(sum_valid_a),  64'd1);
    check("basic_hold_ready", 64'(prod_ready_a), 64'd0);
    check("sat_ovf_hold",     64'(ovf_b),        64'd1);
    take_sum();
    @(negedge clk);
    check("basic_idle", 64'(busy_a), 64'd0);

    // Zero length: straight to HOLD with a zero sum, overflow cleared.
    start_vec(8'd0);
    expect_sum(40'h0, 1'b0, 40'h0, 1'b0);
    @(negedge clk);
    check("zero_prod_ready", 64'(prod_ready_a), 64'd0);
    check("zero_sum_valid",  64'(sum_valid_a),  64'd1);
    check("zero_ovf_b_clr",  64'(ovf_b),        64'd0);
    take_sum();
    @(negedge clk);
    check("zero_idle", 64'(busy_a), 64'd0);

    // Gapped products, stalled sink, start_i pulsed throughout HOLD.
    start_vec(8'd2);
    send_prod(32'h00000000);
    repeat (3) step();
    send_prod(32'h4C468000);
    expect_sum(40'h4C468000, 1'b0, 40'h4C468000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd7;
      @(negedge clk);
      check("bp_sum_valid",  64'(sum_valid_a),  64'd1);
      check("bp_prod_ready", 64'(prod_ready_a), 64'd0);
      check("bp_sum_stable", 64'(sum_a),        64'h4C468000);
      step();
    end
    start = 1'b1;
    len   = 8'd1;
    take_sum();
    start = 1'b0;
    @(negedge clk);
    check("bp_start_ignored_a", 64'(busy_a), 64'd0);
    check("bp_start_ignored_b", 64'(busy_b), 64'd0);

    // Reset mid-vector, with a product presented on the reset edge.
    start_vec(8'd4);
    send_prod(32'h1);
    send_prod(32'h2);
    rst = 1'b1;
    prod_valid = 1'b1;
    prod = 32'h3;
    step();
    rst = 1'b0;
    prod_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",       64'(busy_a),       64'd0);
    check("mid_rst_prod_ready", 64'(prod_ready_a), 64'd0);
    check("mid_rst_sum_valid",  64'(sum_valid_a),  64'd0);
    check("mid_rst_sum",        64'(sum_a),        64'd0);
    check("mid_rst_ovf",        64'(ovf_a),        64'd0);
    start_vec(8'd1);
    send_prod(32'h5);
    expect_sum(40'h5, 1'b0, 40'h5, 1'b0);
    take_sum();

    // Back-to-back vectors: second start in the first IDLE cycle.
    start_vec(8'd1);
    send_prod(32'h9);
    expect_sum(40'h9, 1'b0, 40'h9, 1'b0);
    take_sum();
    start_vec(8'd1);
    send_prod(32'h1);
    expect_sum(40'h1, 1'b0, 40'h1, 1'b0);
    take_sum();

    repeat (2) step();
    check("pending_a", 64'(qa.size()), 64'd0);
    check("pending_b", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
